// File: rtl/aap_decode_queue.sv
// -----------------------------------------------------------------------------
// aap_decode_queue
//   Registered AAP decode stage between fetch and execute. It takes 16-bit
//   instruction parcels, pairs them into 32-bit instructions when bit 15 of
//   the first parcel is set, and tracks the PC of every instruction. Completed
//   instructions wait in a DEPTH-entry FIFO. The FIFO head is decoded
//   combinationally onto dec_*.
//
//   Ports
//     clock, reset_n     rising-edge clock, asynchronous active-low reset
//     fetch_word/valid   incoming parcel; fetch_ready accepts it
//     flush, flush_pc    drop all in-flight state and reload the PC
//     dec_valid/ready    FIFO head handshake towards execute
//     dec_*              decoded fields of the FIFO head (all 0 when empty)
// -----------------------------------------------------------------------------
module aap_decode_queue #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 24,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [15:0]       fetch_word,
  input  logic              fetch_valid,
  output logic              fetch_ready,
  input  logic              flush,
  input  logic [PC_W-1:0]   flush_pc,
  output logic              dec_valid,
  input  logic              dec_ready,
  output logic              dec_long,
  output logic [5:0]        dec_opcode,
  output logic [5:0]        dec_dest,
  output logic [5:0]        dec_src1,
  output logic [5:0]        dec_src2,
  output logic [15:0]       dec_uimm,
  output logic [DATA_W-1:0] dec_simm,
  output logic              dec_ext_a,
  output logic              dec_ext_b,
  output logic [PC_W-1:0]   dec_pc
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic { WAIT1, WAIT2 } state_e;

  // Raw instruction record. Bit 15 of the first parcel only selects the length,
  // so it is not stored.
  typedef struct packed {
    logic            is_long;
    logic [14:0]     hi;
    logic [15:0]     lo;
    logic [PC_W-1:0] pc;
  } rec_t;

  state_e           state_q, state_d;
  logic [14:0]      hi_q, hi_d;
  logic [PC_W-1:0]  hi_pc_q, hi_pc_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  rec_t             mem_q [DEPTH];

  logic accept, enq, deq;
  rec_t enq_rec, head;

  // Ready depends only on the registered count and flush. dec_ready is not used
  // here, so a full queue refuses parcels even while the head is being consumed.
  assign fetch_ready = (count_q < CNT_W'(DEPTH)) & ~flush;
  assign accept      = fetch_valid & fetch_ready;
  assign dec_valid   = (count_q != '0);
  assign deq         = dec_valid & dec_ready & ~flush;
  assign head        = mem_q[rd_ptr_q];

  // Parcel assembly FSM and PC tracking.
  // NOTE: every signal assigned in a combinational block gets a default first,
  // so a missed branch cannot infer a latch.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    hi_pc_d = hi_pc_q;
    pc_d    = pc_q;
    enq     = 1'b0;
    enq_rec = '0;
    if (flush) begin
      state_d = WAIT1;
      pc_d    = flush_pc;
    end else if (accept) begin
      pc_d = pc_q + 1'b1;
      unique case (state_q)
        WAIT1: begin
          if (fetch_word[15]) begin
            hi_d    = fetch_word[14:0];
            hi_pc_d = pc_q;
            state_d = WAIT2;
          end else begin
            enq        = 1'b1;
            enq_rec.hi = fetch_word[14:0];
            enq_rec.pc = pc_q;
          end
        end
        WAIT2: begin
          enq             = 1'b1;
          enq_rec.is_long = 1'b1;
          enq_rec.hi      = hi_q;
          enq_rec.lo      = fetch_word;
          enq_rec.pc      = hi_pc_q;
          state_d         = WAIT1;
        end
        default: state_d = WAIT1;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples
  // the values from before the clock edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= WAIT1;
      hi_q     <= '0;
      hi_pc_q  <= '0;
      pc_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      hi_pc_q <= hi_pc_d;
      pc_q    <= pc_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
        if (enq && !deq)      count_q <= count_q + 1'b1;
        else if (!enq && deq) count_q <= count_q - 1'b1;
      end
    end
  end

  // NOTE: the record storage has no reset. An entry is read only after it has
  // been written, and the outputs are masked while the queue is empty.
  always_ff @(posedge clock) begin
    if (enq) mem_q[wr_ptr_q] <= enq_rec;
  end

  // Decode the FIFO head. Short forms zero-extend the 3-bit register fields.
  // Long forms place the second parcel's bits above the first parcel's bits.
  always_comb begin
    dec_long   = 1'b0;
    dec_opcode = '0;
    dec_dest   = '0;
    dec_src1   = '0;
    dec_src2   = '0;
    dec_uimm   = '0;
    dec_simm   = '0;
    dec_ext_a  = 1'b0;
    dec_ext_b  = 1'b0;
    dec_pc     = '0;
    if (dec_valid) begin
      dec_opcode = head.hi[14:9];
      dec_pc     = head.pc;
      if (head.is_long) begin
        dec_long  = 1'b1;
        dec_dest  = {head.lo[8:6], head.hi[8:6]};
        dec_src1  = {head.lo[5:3], head.hi[5:3]};
        dec_src2  = {head.lo[2:0], head.hi[2:0]};
        dec_uimm  = {head.lo[5:0], head.lo[12:9], head.hi[5:0]};
        dec_simm  = DATA_W'($signed({head.lo[12:0], head.hi[8:0]}));
        dec_ext_a = |head.lo[15:9];
        dec_ext_b = head.lo[9];
      end else begin
        dec_dest  = {3'b000, head.hi[8:6]};
        dec_src1  = {3'b000, head.hi[5:3]};
        dec_src2  = {3'b000, head.hi[2:0]};
        dec_uimm  = {10'b0, head.hi[5:0]};
        dec_simm  = DATA_W'($signed(head.hi[8:0]));
      end
    end
  end

endmodule

// File: tb/tb_aap_decode_queue.sv
// -----------------------------------------------------------------------------
// tb_aap_decode_queue
//   Self-checking bench for aap_decode_queue. A table of instructions with
//   hand-derived decode results is driven in a loop. Every completed
//   instruction pushes its expected record onto a scoreboard. A monitor pops
//   that record when the DUT hands the head over to execute. Hand-written
//   sequences cover back-pressure, flush, PC wrap and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_aap_decode_queue;

  localparam int DEPTH  = 4;
  localparam int PC_W   = 24;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic        is_long;
    logic [5:0]  opcode;
    logic [5:0]  dest;
    logic [5:0]  src1;
    logic [5:0]  src2;
    logic [15:0] uimm;
    logic [31:0] simm;
    logic        ext_a;
    logic        ext_b;
    logic [23:0] pc;
  } exp_t;

  typedef struct packed {
    logic        is_long;
    logic [15:0] p0;
    logic [15:0] p1;
    exp_t        e;
  } vec_t;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [15:0]       fetch_word;
  logic              fetch_valid;
  logic              fetch_ready;
  logic              flush;
  logic [PC_W-1:0]   flush_pc;
  logic              dec_valid;
  logic              dec_ready;
  logic              dec_long;
  logic [5:0]        dec_opcode, dec_dest, dec_src1, dec_src2;
  logic [15:0]       dec_uimm;
  logic [DATA_W-1:0] dec_simm;
  logic              dec_ext_a, dec_ext_b;
  logic [PC_W-1:0]   dec_pc;

  aap_decode_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .DATA_W(DATA_W)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .fetch_word  (fetch_word),
    .fetch_valid (fetch_valid),
    .fetch_ready (fetch_ready),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .dec_valid   (dec_valid),
    .dec_ready   (dec_ready),
    .dec_long    (dec_long),
    .dec_opcode  (dec_opcode),
    .dec_dest    (dec_dest),
    .dec_src1    (dec_src1),
    .dec_src2    (dec_src2),
    .dec_uimm    (dec_uimm),
    .dec_simm    (dec_simm),
    .dec_ext_a   (dec_ext_a),
    .dec_ext_b   (dec_ext_b),
    .dec_pc      (dec_pc)
  );

  always #5 clock = ~clock;

  exp_t act;
  assign act = {dec_long, dec_opcode, dec_dest, dec_src1, dec_src2, dec_uimm,
                dec_simm, dec_ext_a, dec_ext_b, dec_pc};

  int          checks = 0;
  int          errors = 0;
  exp_t        sb[$];
  logic [23:0] exp_pc = '0;
  vec_t        vecs[7];

  task automatic check(input string name, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, a, e);
    end
  endtask

  function automatic vec_t mk(input logic l, input logic [15:0] p0, input logic [15:0] p1,
                              input logic [5:0] op, input logic [5:0] d, input logic [5:0] s1,
                              input logic [5:0] s2, input logic [15:0] u, input logic [31:0] s,
                              input logic ea, input logic eb);
    vec_t v;
    v.is_long   = l;   v.p0 = p0;        v.p1 = p1;
    v.e.is_long = l;   v.e.opcode = op;  v.e.dest = d;
    v.e.src1    = s1;  v.e.src2 = s2;    v.e.uimm = u;
    v.e.simm    = s;   v.e.ext_a = ea;   v.e.ext_b = eb;
    v.e.pc      = '0;
    return v;
  endfunction

  // Reference decode of a short parcel, written from the field layout.
  function automatic exp_t model_short(input logic [15:0] h, input logic [23:0] pc);
    exp_t e;
    e         = '0;
    e.opcode  = h[14:9];
    e.dest    = 6'(h[8:6]);
    e.src1    = 6'(h[5:3]);
    e.src2    = 6'(h[2:0]);
    e.uimm    = 16'(h[5:0]);
    e.simm    = {{23{h[8]}}, h[8:0]};
    e.pc      = pc;
    return e;
  endfunction

  // Scoreboard monitor: a head handshake commits on the next rising edge.
  always @(negedge clock) begin
    if (reset_n === 1'b1 && flush === 1'b0 && dec_valid === 1'b1 && dec_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got record %0h expected none", act);
      end else begin
        check("sb_head", act, sb.pop_front());
      end
    end
  end

  task automatic send_parcel(input logic [15:0] w);
    bit got = 1'b0;
    fetch_word  = w;
    fetch_valid = 1'b1;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clock);
      got = fetch_ready;
      @(posedge clock); #1;
    end
    fetch_valid = 1'b0;
    if (got) exp_pc = exp_pc + 1'b1;
    else begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got fetch_ready=0 expected 1 for parcel %h", w);
    end
  endtask

  task automatic send_instr(input vec_t v);
    exp_t e;
    e    = v.e;
    e.pc = exp_pc;
    send_parcel(v.p0);
    if (v.is_long) send_parcel(v.p1);
    sb.push_back(e);
  endtask

  task automatic send_short(input logic [15:0] w);
    exp_t e;
    e = model_short(w, exp_pc);
    send_parcel(w);
    sb.push_back(e);
  endtask

  task automatic do_flush(input logic [23:0] pc);
    flush    = 1'b1;
    flush_pc = pc;
    @(negedge clock);
    check("flush_cycle_fetch_ready", fetch_ready, 0);
    @(posedge clock); #1;
    flush       = 1'b0;
    fetch_valid = 1'b0;
    sb.delete();
    exp_pc = pc;
    @(negedge clock);
    check("post_flush_dec_valid", dec_valid, 0);
    check("post_flush_fetch_ready", fetch_ready, 1);
    @(posedge clock); #1;
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clock);
      done = (sb.size() == 0) && (dec_valid === 1'b0);
    end
    @(posedge clock); #1;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int   acc;
    exp_t e;

    // Hand-derived decode table.
    vecs[0] = mk(0, 16'h1A53, 16'h0000, 6'h0D, 6'h01, 6'h02, 6'h03, 16'h0013, 32'h0000_0053, 0, 0);
    vecs[1] = mk(0, 16'h7FFF, 16'h0000, 6'h3F, 6'h07, 6'h07, 6'h07, 16'h003F, 32'hFFFF_FFFF, 0, 0);
    vecs[2] = mk(0, 16'h0100, 16'h0000, 6'h00, 6'h04, 6'h00, 6'h00, 16'h0000, 32'hFFFF_FF00, 0, 0);
    vecs[3] = mk(1, 16'h81FF, 16'h1E3F, 6'h00, 6'h07, 6'h3F, 6'h3F, 16'hFFFF, 32'hFFFC_7FFF, 1, 1);
    vecs[4] = mk(1, 16'h9A53, 16'h0000, 6'h0D, 6'h01, 6'h02, 6'h03, 16'h0013, 32'h0000_0053, 0, 0);
    vecs[5] = mk(1, 16'h8000, 16'h0C00, 6'h00, 6'h00, 6'h00, 6'h00, 16'h0180, 32'h0018_0000, 1, 0);
    vecs[6] = mk(1, 16'h8E49, 16'h8FB6, 6'h07, 6'h31, 6'h31, 6'h31, 16'hD9C9, 32'h001F_6C49, 1, 1);

    reset_n     = 1'b0;
    fetch_word  = '0;
    fetch_valid = 1'b0;
    flush       = 1'b0;
    flush_pc    = '0;
    dec_ready   = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset_dec_valid", dec_valid, 0);
    check("reset_outputs", act, 0);
    check("reset_fetch_ready", fetch_ready, 1);
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;

    // Flush to 0x100, one short parcel, visible in the following cycle.
    do_flush(24'h000100);
    send_instr(vecs[0]);
    @(negedge clock);
    check("t1_dec_valid", dec_valid, 1);
    e    = vecs[0].e;
    e.pc = 24'h000100;
    check("t1_head", act, e);
    @(posedge clock); #1;
    dec_ready = 1'b1;
    wait_drain();

    // Table loop, with execute always ready.
    for (int i = 0; i < 7; i++) send_instr(vecs[i]);
    wait_drain();

    // Back-pressure: offer DEPTH+2 parcels, exactly DEPTH are taken.
    dec_ready   = 1'b0;
    acc         = 0;
    fetch_valid = 1'b1;
    for (int c = 0; c < DEPTH + 2; c++) begin
      fetch_word = 16'h0240 + 16'(acc);
      @(negedge clock);
      if (fetch_ready) begin
        sb.push_back(model_short(fetch_word, exp_pc));
        exp_pc = exp_pc + 1'b1;
        acc++;
      end
      @(posedge clock); #1;
    end
    fetch_valid = 1'b0;
    check("fill_accepted", acc, DEPTH);
    @(negedge clock);
    check("full_fetch_ready", fetch_ready, 0);
    @(posedge clock); #1;
    dec_ready = 1'b1;
    @(negedge clock);
    check("full_fetch_ready_with_deq", fetch_ready, 0);
    @(posedge clock); #1;
    wait_drain();

    // Long first parcel, then flush: nothing emitted, next parcel is short at 0x40.
    send_parcel(16'h8000);
    @(negedge clock);
    check("t4_no_valid", dec_valid, 0);
    @(posedge clock); #1;
    do_flush(24'h000040);
    send_short(16'h0000);
    wait_drain();

    // Full queue, then flush with a parcel offered in the same cycle.
    dec_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send_short(16'h0300 + 16'(i));
    fetch_word  = 16'h7777;
    fetch_valid = 1'b1;
    do_flush(24'h000200);
    send_short(16'h0005);
    dec_ready = 1'b1;
    wait_drain();

    // PC wrap.
    do_flush(24'hFFFFFF);
    send_short(16'h1234);
    send_short(16'h0ABC);
    wait_drain();

    // Asynchronous reset in the middle of a long pair with records queued.
    dec_ready = 1'b0;
    send_short(16'h0111);
    send_short(16'h0222);
    send_parcel(16'h8123);
    @(posedge clock); #3;
    reset_n = 1'b0;
    #1;
    check("async_reset_dec_valid", dec_valid, 0);
    check("async_reset_outputs", act, 0);
    check("async_reset_fetch_ready", fetch_ready, 1);
    sb.delete();
    exp_pc = '0;
    @(negedge clock) reset_n = 1'b1;
    @(posedge clock); #1;
    send_instr(vecs[0]);
    dec_ready = 1'b1;
    wait_drain();

    check("sb_empty_at_end", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
